cur_blk_rd: RTL and testbench

//  Reader/requester side of the current-LCU pixel buffer read port (sel/ren/size/4x4_x/4x4_y/idx -> 32-pixel data).
//  On start, walks every read beat of one square block, issues buffer reads, absorbs read latency in a small FIFO,
//  and streams rows to a downstream consumer over valid/ready, flagging the last beat. Feeds TQ/IME-style consumers.

---
 rtl/cur_blk_rd_pkg.sv | 33 +++
 rtl/cur_blk_rd_if.sv | 13 +
 rtl/cur_blk_rd_fifo.sv | 60 ++++++
 rtl/cur_blk_rd.sv | 156 +++++++++++++++
 tb/tb_cur_blk_rd.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cur_blk_rd_pkg.sv
// Shared types and constants for the current-LCU block reader.
// Pixel width, block-size encodings, beats-per-size table, FSM states, position alignment.
package cur_blk_rd_pkg;

    localparam int unsigned PIXEL_WIDTH = 8;
    localparam int unsigned DATA_W      = PIXEL_WIDTH * 32;

    typedef enum logic [1:0] {
        SIZE_4X4   = 2'b00,
        SIZE_8X8   = 2'b01,
        SIZE_16X16 = 2'b10,
        SIZE_32X32 = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // One 32-pixel beat per table entry: 16/64/256/1024 pixels per block.
    localparam logic [5:0] BEATS_TBL [4] = '{6'd1, 6'd2, 6'd8, 6'd32};

    function automatic logic [3:0] align_pos(input logic [3:0] pos, input size_e sz);
        case (sz)
            SIZE_8X8:   return {pos[3:1], 1'b0};
            SIZE_16X16: return {pos[3:2], 2'b00};
            SIZE_32X32: return {pos[3], 3'b000};
            default:    return pos;
        endcase
    endfunction

endpackage

// File: rtl/cur_blk_rd_if.sv
// Beat stream from the block reader to its consumer (valid/ready with last flag).
interface cur_blk_rd_if;
    import cur_blk_rd_pkg::*;

    logic              valid;
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;

    modport master (output valid, output last, output data, input ready);
    modport slave  (input valid, input last, input data, output ready);

endinterface

// File: rtl/cur_blk_rd_fifo.sv
// Synchronous FIFO holding returned read beats; arbitrary DEPTH, occupancy count out.
module cur_blk_rd_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 257
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cur_blk_rd.sv
// Current-LCU block reader: walks all read beats of one block, absorbs read latency, streams beats out.
// Optional CUR_BLK_RD_STAT_EN adds stall_cnt (stalled-output cycles in the current block).
module cur_blk_rd
    import cur_blk_rd_pkg::*;
#(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sel,
    input  logic [1:0]        size,
    input  logic [3:0]        pos_x,
    input  logic [3:0]        pos_y,
    output logic              busy,
    output logic              done,
    output logic              cur_sel,
    output logic              cur_ren,
    output logic [1:0]        cur_size,
    output logic [3:0]        cur_pos_x,
    output logic [3:0]        cur_pos_y,
    output logic [4:0]        cur_idx,
    input  logic [DATA_W-1:0] cur_data,
    cur_blk_rd_if.master      blk
`ifdef CUR_BLK_RD_STAT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

    state_e              state;
    state_e              state_nxt;
    logic                sel_q;
    size_e               size_q;
    logic [3:0]          x_q;
    logic [3:0]          y_q;
    logic [5:0]          idx;
    logic [5:0]          beats;
    logic [RD_LAT-1:0]   sr_vld;
    logic [RD_LAT-1:0]   sr_last;
    logic [FCNT_W-1:0]   fifo_cnt;
    logic [OCNT_W-1:0]   inflight;
    logic [OCNT_W-1:0]   outstanding;
    logic [DATA_W:0]     fifo_rdata;
    logic                accept;
    logic                issue;
    logic                last_issue;
    logic                pop;

    always_comb begin
        accept   = (state == ST_IDLE) && start;
        beats    = BEATS_TBL[size_q];
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OCNT_W'(sr_vld[i]);
        end
        // Issue decision uses registered occupancy only, so ready never reaches ren combinationally.
        outstanding = OCNT_W'(fifo_cnt) + inflight;
        issue       = (state == ST_RUN) && (idx < beats) && (outstanding < OCNT_W'(FIFO_DEPTH));
        last_issue  = issue && (idx == beats - 6'd1);

        blk.valid = (fifo_cnt != '0);
        blk.last  = blk.valid && fifo_rdata[DATA_W];
        blk.data  = blk.valid ? fifo_rdata[DATA_W-1:0] : '0;
        pop       = blk.valid && blk.ready;
        done      = (state == ST_DRAIN) && pop && blk.last;

        busy      = (state != ST_IDLE);
        cur_ren   = issue;
        cur_sel   = busy && sel_q;
        cur_size  = busy ? size_q : '0;
        cur_pos_x = busy ? x_q : '0;
        cur_pos_y = busy ? y_q : '0;
        cur_idx   = busy ? idx[4:0] : '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)      state_nxt = ST_RUN;
            ST_RUN:   if (last_issue) state_nxt = ST_DRAIN;
            ST_DRAIN: if (done)       state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 1'b0;
            size_q <= SIZE_4X4;
            x_q    <= '0;
            y_q    <= '0;
            idx    <= '0;
        end else if (accept) begin
            sel_q  <= sel;
            size_q <= size_e'(size);
            x_q    <= align_pos(pos_x, size_e'(size));
            y_q    <= align_pos(pos_y, size_e'(size));
            idx    <= '0;
        end else if (issue) begin
            idx <= idx + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_vld  <= '0;
            sr_last <= '0;
        end else begin
            sr_vld[0]  <= issue;
            sr_last[0] <= last_issue;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                sr_vld[i]  <= sr_vld[i-1];
                sr_last[i] <= sr_last[i-1];
            end
        end
    end

    cur_blk_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (sr_vld[RD_LAT-1]),
        .wdata ({sr_last[RD_LAT-1], cur_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_cnt)
    );

`ifdef CUR_BLK_RD_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (busy && blk.valid && !blk.ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cur_blk_rd.sv
// Directed bench for cur_blk_rd with a 1-cycle-latency buffer model; also builds with CUR_BLK_RD_STAT_EN.
module tb_cur_blk_rd;
    import cur_blk_rd_pkg::*;

    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned FIFO_DEPTH = 3;
    localparam logic [DATA_W-1:0] JUNK = {8{32'hDEAD_BEEF}};

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              sel   = 1'b0;
    logic [1:0]        size  = 2'b00;
    logic [3:0]        pos_x = '0;
    logic [3:0]        pos_y = '0;
    logic              busy;
    logic              done;
    logic              cur_sel;
    logic              cur_ren;
    logic [1:0]        cur_size;
    logic [3:0]        cur_pos_x;
    logic [3:0]        cur_pos_y;
    logic [4:0]        cur_idx;
    logic [DATA_W-1:0] cur_data;
`ifdef CUR_BLK_RD_STAT_EN
    logic [15:0]       stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    cur_blk_rd_if blk();

    always #5 clk = ~clk;

    cur_blk_rd #(
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel       (sel),
        .size      (size),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .busy      (busy),
        .done      (done),
        .cur_sel   (cur_sel),
        .cur_ren   (cur_ren),
        .cur_size  (cur_size),
        .cur_pos_x (cur_pos_x),
        .cur_pos_y (cur_pos_y),
        .cur_idx   (cur_idx),
        .cur_data  (cur_data),
        .blk       (blk)
`ifdef CUR_BLK_RD_STAT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Buffer content encodes the request so misordered or misaddressed beats are visible.
    function automatic logic [DATA_W-1:0] mk_data(input logic s, input logic [1:0] sz,
                                                  input logic [3:0] x, input logic [3:0] y,
                                                  input logic [4:0] i);
        logic [31:0] w;
        w = {16'hC0DE, s, sz, x, y, i};
        return {8{w}};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cur_data <= JUNK;
        else if (cur_ren) cur_data <= mk_data(cur_sel, cur_size, cur_pos_x, cur_pos_y, cur_idx);
        else              cur_data <= JUNK;
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always 1; mode 1: ready on even cycles; mode 2: ready low for cycles 4..23
    task automatic run_block(input string tag, input logic s, input logic [1:0] sz,
                             input logic [3:0] x, input logic [3:0] y,
                             input logic [3:0] ax, input logic [3:0] ay,
                             input int mode, input int nbeats);
        int   issued   = 0;
        int   popped   = 0;
        int   done_cnt = 0;
        int   stalls   = 0;
        int   max_out  = 0;
        int   c        = 0;
        logic fin      = 1'b0;
        logic pend     = 1'b0;
        @(negedge clk);
        start = 1'b1; sel = s; size = sz; pos_x = x; pos_y = y;
        while (!fin && c < 400) begin
            @(negedge clk);
            start = 1'b0;
            case (mode)
                1:       blk.ready = (c % 2 == 0);
                2:       blk.ready = !(c >= 4 && c < 24);
                default: blk.ready = 1'b1;
            endcase
            #1;
            if (c == 0) chk({tag, " busy"}, busy, 1'b1);
            if (cur_ren) begin
                chk({tag, " idx"},  cur_idx, issued[4:0]);
                chk({tag, " size"}, cur_size, sz);
                chk({tag, " sel"},  cur_sel, s);
                chk({tag, " x"},    cur_pos_x, ax);
                chk({tag, " y"},    cur_pos_y, ay);
                issued++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (mode == 2 && c == 23) chk({tag, " issued_in_stall"}, issued, 5);
            if (pend) chk({tag, " valid_held"}, blk.valid, 1'b1);
            pend = 1'b0;
            if (blk.valid) begin
                chk({tag, " data"}, blk.data, mk_data(s, sz, ax, ay, popped[4:0]));
                chk({tag, " last"}, blk.last, (popped == nbeats - 1));
                if (blk.ready) begin
                    chk({tag, " done_at_pop"}, done, (popped == nbeats - 1));
                    popped++;
                end else begin
                    stalls++;
                    pend = 1'b1;
                end
            end
            if (done) begin
                done_cnt++;
                fin = 1'b1;
            end
            c++;
        end
        chk({tag, " finished_in_budget"}, fin, 1'b1);
        @(negedge clk);
        #1;
        chk({tag, " busy_after"}, busy, 1'b0);
        chk({tag, " done_once"}, done_cnt, 1);
        chk({tag, " beats"}, popped, nbeats);
        chk({tag, " reads"}, issued, nbeats);
        if (mode == 2) chk({tag, " max_outstanding"}, max_out, FIFO_DEPTH);
        else           chk({tag, " outstanding_bound"}, (max_out <= FIFO_DEPTH), 1'b1);
`ifdef CUR_BLK_RD_STAT_EN
        chk({tag, " stall_cnt"}, stall_cnt, stalls[15:0]);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        blk.ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst ren", cur_ren, 1'b0);
        chk("rst valid", blk.valid, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst size", cur_size, 2'b00);
        chk("rst idx", cur_idx, 5'd0);
        rst_n = 1'b1;

        run_block("b32",    1'b0, 2'b11, 4'd0, 4'd0, 4'd0, 4'd0, 0, 32);
        run_block("b4",     1'b1, 2'b00, 4'd5, 4'd3, 4'd5, 4'd3, 0, 1);
        run_block("b16",    1'b0, 2'b10, 4'd6, 4'd5, 4'd4, 4'd4, 0, 8);
        run_block("b8tog",  1'b1, 2'b01, 4'd3, 4'd7, 4'd2, 4'd6, 1, 2);
        run_block("b32stl", 1'b0, 2'b11, 4'd13, 4'd10, 4'd8, 4'd8, 2, 32);

        // Start while busy is ignored, then reset aborts the block.
        @(negedge clk);
        start = 1'b1; sel = 1'b1; size = 2'b11; pos_x = 4'd9; pos_y = 4'd9;
        blk.ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; sel = 1'b0; size = 2'b00; pos_x = 4'd1; pos_y = 4'd1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("ign busy", busy, 1'b1);
        chk("ign size", cur_size, 2'b11);
        chk("ign sel", cur_sel, 1'b1);
        chk("ign x", cur_pos_x, 4'd8);
        chk("ign y", cur_pos_y, 4'd8);
        chk("ign valid", blk.valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort ren", cur_ren, 1'b0);
        chk("abort sel", cur_sel, 1'b0);
        chk("abort size", cur_size, 2'b00);
        chk("abort x", cur_pos_x, 4'd0);
        chk("abort y", cur_pos_y, 4'd0);
        chk("abort idx", cur_idx, 5'd0);
        chk("abort valid", blk.valid, 1'b0);
        chk("abort last", blk.last, 1'b0);
        chk("abort data", blk.data, '0);
        chk("abort done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        blk.ready = 1'b1;

        run_block("post", 1'b0, 2'b01, 4'd1, 4'd1, 4'd0, 4'd0, 0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
